linear_regression_training: RTL

- Upstream training stage for the prediction stage. Collects a batch of NUM_SAMPLES (x, y) pairs, computes the closed-form least-squares fit y = theta1*x + theta0 in integer arithmetic, and presents theta0/theta1 with a level-held valid flag.
- Those outputs drive the predictor's i_theta0_out, i_theta1_out and i_theta1_out_vld inputs directly.
- Uses running-sum accumulation and one shared multi-cycle restoring divider.

---
 rtl/linear_regression_training.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/linear_regression_training.sv
// Purpose : collects NUM_SAMPLES (x,y) pairs and fits y = theta1*x + theta0 with one shared restoring divider.
// Latency : thetas and valid update together 2*DIV_W+4 edges after the edge that accepted the last sample.
// Backpr. : o_samples_rdy is high only while accumulating; samples offered while it is low are dropped.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_samples_x_in/i_samples_y_in : sample pair, low 16 bits used as signed
//   i_samples_vld                 : pair valid this cycle
//   i_clear                       : discard partial batch or finished result, start a new batch
//   o_samples_rdy, o_busy         : accepting samples / fit in progress
//   o_theta0_out, o_theta1_out    : intercept and slope, signed 32-bit
//   o_theta1_out_vld              : both thetas valid (level)
//   o_div0_err                    : last batch had all x equal (slope forced to 0)
module linear_regression_training #(
    parameter int NUM_SAMPLES = 8,
    parameter int CNT_W       = 3,
    parameter int DIV_W       = 32 + 2*CNT_W + 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_samples_x_in,
    input  logic [31:0] i_samples_y_in,
    input  logic        i_samples_vld,
    input  logic        i_clear,
    output logic        o_samples_rdy,
    output logic        o_busy,
    output logic [31:0] o_theta0_out,
    output logic [31:0] o_theta1_out,
    output logic        o_theta1_out_vld,
    output logic        o_div0_err
);
    localparam int SW  = 16 + CNT_W;      // width of Sx / Sy
    localparam int PW  = 32 + CNT_W;      // width of Sxx / Sxy
    localparam int TW  = 32 + SW + 1;     // full width of Sy - theta1*Sx
    localparam int DCW = $clog2(DIV_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [DCW-1:0]   LAST_DIV = DCW'(DIV_W - 1);
    localparam logic [DIV_W-1:0] MAG_POS  = DIV_W'(32'h7FFF_FFFF);
    localparam logic [DIV_W-1:0] MAG_NEG  = DIV_W'(32'h8000_0000);

    // FIN is the single edge that moves theta0, theta1 and valid together.
    typedef enum logic [2:0] {
        S_ACCUM, S_CALC1, S_CALC2, S_DIV1, S_PREP0, S_DIV0, S_FIN, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]        count;
    logic signed [SW-1:0]    sx, sy;
    logic signed [PW-1:0]    sxx, sxy;
    logic signed [DIV_W-1:0] num;
    logic                    den_zero;
    logic [31:0]             theta1_q, theta0_q;
    logic [DIV_W-1:0]        div_rem, div_q, div_d;
    logic                    div_neg;
    logic [DCW-1:0]          div_cnt;

    // ---------------- sample terms ----------------
    logic signed [15:0] x_s, y_s;
    logic signed [31:0] x_w, y_w, xx_prod, xy_prod;
    logic signed [SW-1:0] x_sw, y_sw;
    logic signed [PW-1:0] xx_pw, xy_pw;
    logic accept;

    assign x_s     = i_samples_x_in[15:0];
    assign y_s     = i_samples_y_in[15:0];
    assign x_w     = {{16{x_s[15]}}, x_s};
    assign y_w     = {{16{y_s[15]}}, y_s};
    assign xx_prod = x_w * x_w;
    assign xy_prod = x_w * y_w;
    assign x_sw    = {{CNT_W{x_s[15]}}, x_s};
    assign y_sw    = {{CNT_W{y_s[15]}}, y_s};
    assign xx_pw   = {{CNT_W{xx_prod[31]}}, xx_prod};
    assign xy_pw   = {{CNT_W{xy_prod[31]}}, xy_prod};
    assign accept  = i_samples_vld && o_samples_rdy && !i_clear;

    // ---------------- NUM / DEN ----------------
    logic signed [DIV_W-1:0] sx_w, sy_w, sxx_w, sxy_w, num_calc, den_calc;
    logic [DIV_W-1:0] num_mag, den_mag;

    assign sx_w     = {{(DIV_W-SW){sx[SW-1]}}, sx};
    assign sy_w     = {{(DIV_W-SW){sy[SW-1]}}, sy};
    assign sxx_w    = {{(DIV_W-PW){sxx[PW-1]}}, sxx};
    assign sxy_w    = {{(DIV_W-PW){sxy[PW-1]}}, sxy};
    assign num_calc = (sxy_w <<< CNT_W) - sx_w * sy_w;
    assign den_calc = (sxx_w <<< CNT_W) - sx_w * sx_w;
    assign num_mag  = num[DIV_W-1] ? -num : num;
    assign den_mag  = den_calc[DIV_W-1] ? -den_calc : den_calc;

    // ---------------- intercept numerator ----------------
    // |T| beyond the divider range always yields a saturated theta0, so an
    // out-of-range T is replaced by 2^(DIV_W-1) with its sign kept.
    logic signed [TW-1:0] th1_t, sx_t, sy_t, t_full, t_neg;
    logic t_fits;
    logic [DIV_W-1:0] t_mag;

    assign th1_t  = {{(TW-32){theta1_q[31]}}, theta1_q};
    assign sx_t   = {{(TW-SW){sx[SW-1]}}, sx};
    assign sy_t   = {{(TW-SW){sy[SW-1]}}, sy};
    assign t_full = sy_t - th1_t * sx_t;
    assign t_neg  = -t_full;
    assign t_fits = (&t_full[TW-1:DIV_W-1]) | ~(|t_full[TW-1:DIV_W-1]);
    assign t_mag  = !t_fits          ? {1'b1, {(DIV_W-1){1'b0}}} :
                    t_full[TW-1]     ? t_neg[DIV_W-1:0] : t_full[DIV_W-1:0];

    // ---------------- restoring divider step ----------------
    logic [DIV_W:0]   div_shift;
    logic [DIV_W+1:0] div_trial;
    logic             div_take;
    logic [DIV_W-1:0] div_q_last;
    logic [31:0]      div_res;

    assign div_shift  = {div_rem, div_q[DIV_W-1]};
    assign div_trial  = {1'b0, div_shift} - {2'b00, div_d};
    assign div_take   = ~div_trial[DIV_W+1];
    assign div_q_last = {div_q[DIV_W-2:0], div_take};

    // Quotient after the final step, sign-restored and clamped to 32 bits.
    always_comb begin
        div_res = div_q_last[31:0];
        if (div_neg) begin
            if (div_q_last > MAG_NEG) div_res = 32'h8000_0000;
            else                      div_res = 32'd0 - div_q_last[31:0];
        end else if (div_q_last > MAG_POS) begin
            div_res = 32'h7FFF_FFFF;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_samples_x_in[31:16], i_samples_y_in[31:16],
                           div_trial[DIV_W], t_neg[TW-1:DIV_W]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= S_ACCUM;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_ACCUM: if (accept && count == LAST_CNT) state_nxt = S_CALC1;
            S_CALC1: state_nxt = S_CALC2;
            S_CALC2: state_nxt = S_DIV1;
            S_DIV1:  if (div_cnt == LAST_DIV) state_nxt = S_PREP0;
            S_PREP0: state_nxt = S_DIV0;
            S_DIV0:  if (div_cnt == LAST_DIV) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_DONE;
            S_DONE:  if (i_clear) state_nxt = S_ACCUM;
            default: state_nxt = S_ACCUM;
        endcase
    end

    // ---------------- FSM: outputs decoded from state ----------------
    always_comb begin
        o_samples_rdy = (state == S_ACCUM);
        o_busy        = (state != S_ACCUM) && (state != S_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count            <= '0;
            sx               <= '0;
            sy               <= '0;
            sxx              <= '0;
            sxy              <= '0;
            num              <= '0;
            den_zero         <= 1'b0;
            theta1_q         <= '0;
            theta0_q         <= '0;
            div_rem          <= '0;
            div_q            <= '0;
            div_d            <= '0;
            div_neg          <= 1'b0;
            div_cnt          <= '0;
            o_theta0_out     <= '0;
            o_theta1_out     <= '0;
            o_theta1_out_vld <= 1'b0;
            o_div0_err       <= 1'b0;
        end else begin
            unique case (state)
                S_ACCUM: begin
                    if (i_clear) begin
                        count <= '0;
                        sx    <= '0;
                        sy    <= '0;
                        sxx   <= '0;
                        sxy   <= '0;
                    end else if (accept) begin
                        // count wraps to zero on the last sample of the batch
                        count <= count + CNT_W'(1);
                        sx    <= sx + x_sw;
                        sy    <= sy + y_sw;
                        sxx   <= sxx + xx_pw;
                        sxy   <= sxy + xy_pw;
                    end
                end
                S_CALC1: num <= num_calc;
                S_CALC2: begin
                    den_zero <= (den_calc == '0);
                    div_rem  <= '0;
                    div_q    <= num_mag;
                    div_d    <= den_mag;
                    div_neg  <= num[DIV_W-1] ^ den_calc[DIV_W-1];
                    div_cnt  <= '0;
                end
                S_DIV1, S_DIV0: begin
                    // With a zero divisor the steps still run, keeping latency fixed; the result is discarded.
                    div_rem <= div_take ? div_trial[DIV_W-1:0] : div_shift[DIV_W-1:0];
                    div_q   <= div_q_last;
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == LAST_DIV) begin
                        if (state == S_DIV1) theta1_q <= den_zero ? 32'd0 : div_res;
                        else                 theta0_q <= div_res;
                    end
                end
                S_PREP0: begin
                    div_rem <= '0;
                    div_q   <= t_mag;
                    div_d   <= DIV_W'(NUM_SAMPLES);
                    div_neg <= t_full[TW-1];
                    div_cnt <= '0;
                end
                S_FIN: begin
                    o_theta0_out     <= theta0_q;
                    o_theta1_out     <= theta1_q;
                    o_theta1_out_vld <= 1'b1;
                    o_div0_err       <= den_zero;
                end
                S_DONE: begin
                    if (i_clear) begin
                        o_theta1_out_vld <= 1'b0;
                        o_div0_err       <= 1'b0;
                        den_zero         <= 1'b0;
                        count            <= '0;
                        sx               <= '0;
                        sy               <= '0;
                        sxx              <= '0;
                        sxy              <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
